// File: rtl/game_pkg.sv
// Shared game definitions: state encoding, screen geometry and the RGB565 palette
// used by the obstacle renderers and the display mux.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_GRACE   = 2'd2,
    ST_OVER    = 2'd3
  } game_state_t;

  localparam int SCREEN_W    = 96;
  localparam int SCREEN_H    = 64;
  localparam int NUM_PIXELS  = SCREEN_W * SCREEN_H;
  localparam int PIXEL_IDX_W = 13;

  localparam logic [15:0] COLOR_BLACK  = 16'h0000;
  localparam logic [15:0] COLOR_WHITE  = 16'hFFFF;
  localparam logic [15:0] COLOR_RED    = 16'hF800;
  localparam logic [15:0] COLOR_GREEN  = 16'h07E0;
  localparam logic [15:0] COLOR_BLUE   = 16'h001F;
  localparam logic [15:0] COLOR_YELLOW = 16'hFFE0;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/frame_tick_detect.sv
// Produces a registered one-cycle frame_end pulse whenever pixel_index moves backwards,
// so a frame still ends even if the scan skips its final pixel.
module frame_tick_detect
  import game_pkg::*;
#(
  parameter int IDX_W = PIXEL_IDX_W
) (
  input  logic             clock_25mhz,
  input  logic             reset,
  input  logic [IDX_W-1:0] pixel_index,
  output logic             frame_end
);

  logic [IDX_W-1:0] prev_pixel_index;

  always_ff @(posedge clock_25mhz) begin
    if (reset) begin
      prev_pixel_index <= '0;
      frame_end        <= 1'b0;
    end else begin
      prev_pixel_index <= pixel_index;
      frame_end        <= (pixel_index < prev_pixel_index);
    end
  end

endmodule

// File: rtl/collision_game_controller.sv
// Game FSM: accumulates player/obstacle overlap over each frame, resolves it at the
// frame boundary, and drives lives, score, speed and the hit-flash flag.
module collision_game_controller
  import game_pkg::*;
#(
  parameter int unsigned START_LIVES  = 3,
  parameter int unsigned GRACE_FRAMES = 60,
  parameter int unsigned SPEED_INIT   = 250000,
  parameter int unsigned SPEED_STEP   = 10000,
  parameter int unsigned SPEED_MIN    = 50000,
  parameter int unsigned LEVEL_FRAMES = 600,
  parameter logic [15:0] SCORE_LOAD   = 16'd0
) (
  input  logic                   clock_25mhz,
  input  logic                   reset,
  input  logic [PIXEL_IDX_W-1:0] pixel_index,
  input  logic                   is_obstacle_hitbox,
  input  logic                   is_player_pixel,
  input  logic                   start_pulse,
  output logic                   game_active,
  output logic                   game_over,
  output logic [1:0]             lives,
  output logic [31:0]            speed,
  output logic [15:0]            score,
  output logic                   hit_flash,
  output game_state_t            state_dbg
);

  localparam logic [31:0] SPEED_INIT_W = 32'(SPEED_INIT);
  localparam logic [31:0] SPEED_STEP_W = 32'(SPEED_STEP);
  localparam logic [31:0] SPEED_MIN_W  = 32'(SPEED_MIN);
  localparam logic [15:0] GRACE_LAST   = 16'(GRACE_FRAMES - 1);
  localparam logic [15:0] LEVEL_LAST   = 16'(LEVEL_FRAMES - 1);

  game_state_t state, state_next;
  logic        frame_end;
  logic        frame_hit;
  logic        coll;
  logic        in_game;
  logic        start_load;
  logic [15:0] level_cnt;
  logic [15:0] grace_cnt;
  logic [31:0] speed_dec;

  frame_tick_detect #(
    .IDX_W(PIXEL_IDX_W)
  ) u_frame_tick (
    .clock_25mhz (clock_25mhz),
    .reset       (reset),
    .pixel_index (pixel_index),
    .frame_end   (frame_end)
  );

  assign coll       = is_obstacle_hitbox & is_player_pixel & (state == ST_PLAYING);
  assign in_game    = (state == ST_PLAYING) || (state == ST_GRACE);
  assign start_load = ((state == ST_IDLE) || (state == ST_OVER)) && start_pulse;
  assign state_dbg  = state;

  always_ff @(posedge clock_25mhz) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_OVER: if (start_pulse) state_next = ST_PLAYING;
      ST_PLAYING: begin
        if (frame_end && frame_hit) state_next = (lives > 2'd1) ? ST_GRACE : ST_OVER;
      end
      ST_GRACE: begin
        if (frame_end && (grace_cnt == GRACE_LAST)) state_next = ST_PLAYING;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    game_active = 1'b0;
    game_over   = 1'b0;
    hit_flash   = 1'b0;
    case (state)
      ST_PLAYING: game_active = 1'b1;
      ST_GRACE: begin
        game_active = 1'b1;
        hit_flash   = 1'b1;
      end
      ST_OVER: game_over = 1'b1;
      default: ;
    endcase
  end

  // Compare first so the subtract can never wrap below the floor.
  always_comb begin
    if (speed >= (SPEED_MIN_W + SPEED_STEP_W)) speed_dec = speed - SPEED_STEP_W;
    else                                       speed_dec = SPEED_MIN_W;
  end

  always_ff @(posedge clock_25mhz) begin
    if (reset) begin
      lives     <= 2'd0;
      speed     <= SPEED_INIT_W;
      score     <= 16'd0;
      level_cnt <= 16'd0;
      grace_cnt <= 16'd0;
      frame_hit <= 1'b0;
    end else if (start_load) begin
      lives     <= 2'(START_LIVES);
      speed     <= SPEED_INIT_W;
      score     <= SCORE_LOAD;
      level_cnt <= 16'd0;
      grace_cnt <= 16'd0;
      frame_hit <= 1'b0;
    end else if (in_game && frame_end) begin
      score <= sat_inc16(score);
      if (level_cnt == LEVEL_LAST) begin
        level_cnt <= 16'd0;
        speed     <= speed_dec;
      end else begin
        level_cnt <= level_cnt + 16'd1;
      end
      if (state == ST_GRACE) grace_cnt <= grace_cnt + 16'd1;
      if ((state == ST_PLAYING) && frame_hit) begin
        lives     <= (lives > 2'd1) ? lives - 2'd1 : 2'd0;
        grace_cnt <= 16'd0;
      end
      // An overlap on the frame_end cycle belongs to the frame that is just starting.
      frame_hit <= coll && (state_next == ST_PLAYING);
    end else if (coll) begin
      frame_hit <= 1'b1;
    end
  end

endmodule

// File: tb/tb_collision_game_controller.sv
// Bench for collision_game_controller: frame-level game model, directed scenarios and a
// randomized run; a second instance checks level-up clamping and score saturation.
module tb_collision_game_controller;

  localparam int P_IDLE = 0, P_PLAYING = 1, P_GRACE = 2, P_OVER = 3;

  logic        clock_25mhz = 1'b0;
  logic        reset = 1'b0;
  logic [12:0] pixel_index = '0;
  logic        is_obstacle_hitbox = 1'b0;
  logic        is_player_pixel = 1'b0;
  logic        start_pulse = 1'b0;

  logic        game_active, game_over, hit_flash;
  logic [1:0]  lives;
  logic [31:0] speed;
  logic [15:0] score;
  logic [1:0]  state_dbg;

  logic        f_game_active, f_game_over, f_hit_flash;
  logic [1:0]  f_lives;
  logic [31:0] f_speed;
  logic [15:0] f_score;
  logic [1:0]  f_state_dbg;

  always #20 clock_25mhz = ~clock_25mhz;

  collision_game_controller dut (
    .clock_25mhz(clock_25mhz), .reset(reset), .pixel_index(pixel_index),
    .is_obstacle_hitbox(is_obstacle_hitbox), .is_player_pixel(is_player_pixel),
    .start_pulse(start_pulse), .game_active(game_active), .game_over(game_over),
    .lives(lives), .speed(speed), .score(score), .hit_flash(hit_flash), .state_dbg(state_dbg)
  );

  collision_game_controller #(.SPEED_INIT(60000), .LEVEL_FRAMES(2), .SCORE_LOAD(16'hFFFE)) dut_fast (
    .clock_25mhz(clock_25mhz), .reset(reset), .pixel_index(pixel_index),
    .is_obstacle_hitbox(is_obstacle_hitbox), .is_player_pixel(is_player_pixel),
    .start_pulse(start_pulse), .game_active(f_game_active), .game_over(f_game_over),
    .lives(f_lives), .speed(f_speed), .score(f_score), .hit_flash(f_hit_flash),
    .state_dbg(f_state_dbg)
  );

  int n_checks = 0;
  int n_pass = 0;

  // Game model, advanced once per resolved frame.
  int m_state = P_IDLE;
  int m_lives = 0;
  int m_frames = 0;
  int m_grace_left = 0;
  bit m_hit = 0;
  bit m_started = 0;
  bit frame_open = 0;
  logic [15:0] exp_q[$];

  function automatic int exp_speed(input int init, input int lvl);
    int s;
    s = init - 10000 * (m_frames / lvl);
    return (s < 50000) ? 50000 : s;
  endfunction

  function automatic int exp_score(input int load);
    int s;
    if (!m_started) return 0;
    s = load + m_frames;
    return (s > 65535) ? 65535 : s;
  endfunction

  task automatic resolve();
    if (m_state == P_PLAYING || m_state == P_GRACE) begin
      m_frames++;
      if (m_state == P_GRACE) begin
        m_grace_left--;
        if (m_grace_left == 0) m_state = P_PLAYING;
      end else if (m_hit) begin
        m_lives--;
        m_state = (m_lives == 0) ? P_OVER : P_GRACE;
        m_grace_left = 60;
      end
    end
    m_hit = 0;
  endtask

  task automatic model_reset();
    m_state = P_IDLE; m_lives = 0; m_frames = 0; m_grace_left = 0;
    m_hit = 0; m_started = 0; frame_open = 0;
  endtask

  task automatic cyc();
    @(posedge clock_25mhz);
    #1;
  endtask

  task automatic set_noise();
    int r;
    r = $urandom_range(0, 3);
    is_obstacle_hitbox = (r == 1);
    is_player_pixel = (r == 2);
  endtask

  // Cycle 0 carries pixel 0; the previous frame resolves on cycle 1.
  task automatic drive_frame(input int n, input int hit_idx, input int stride);
    bit pre_playing;
    int st;
    pre_playing = 0;
    st = (stride > 0) ? stride : $urandom_range(1, 6143 / (n - 1));
    for (int c = 0; c < n; c++) begin
      pixel_index = 13'(c * st);
      set_noise();
      if (c == hit_idx) begin
        is_obstacle_hitbox = 1'b1;
        is_player_pixel = 1'b1;
      end
      if (c == 1) pre_playing = (m_state == P_PLAYING);
      cyc();
      if (c == 1 && frame_open) resolve();
      if (c == hit_idx && c >= 1 && m_state == P_PLAYING && (c >= 2 || pre_playing)) m_hit = 1;
    end
    is_obstacle_hitbox = 1'b0;
    is_player_pixel = 1'b0;
    frame_open = 1;
  endtask

  task automatic idle(input int k);
    for (int c = 0; c < k; c++) begin
      pixel_index = '0;
      set_noise();
      cyc();
      if (c == 1 && frame_open) resolve();
    end
    is_obstacle_hitbox = 1'b0;
    is_player_pixel = 1'b0;
    frame_open = 0;
  endtask

  task automatic press_start();
    idle(3);
    start_pulse = 1'b1;
    cyc();
    start_pulse = 1'b0;
    if (m_state == P_IDLE || m_state == P_OVER) begin
      m_state = P_PLAYING; m_lives = 3; m_frames = 0; m_hit = 0; m_started = 1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pixel_index = '0;
    start_pulse = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clock_25mhz);
    n_checks++; if (state_dbg !== 2'(P_IDLE)) $display("FAIL reset_state got %0d exp %0d", state_dbg, P_IDLE); else n_pass++;
    n_checks++; if (game_active !== 1'b0) $display("FAIL reset_active got %0b exp 0", game_active); else n_pass++;
    n_checks++; if (game_over !== 1'b0) $display("FAIL reset_over got %0b exp 0", game_over); else n_pass++;
    n_checks++; if (lives !== 2'd0) $display("FAIL reset_lives got %0d exp 0", lives); else n_pass++;
    n_checks++; if (speed !== 32'd250000) $display("FAIL reset_speed got %0d exp 250000", speed); else n_pass++;
    n_checks++; if (score !== 16'd0) $display("FAIL reset_score got %0d exp 0", score); else n_pass++;
    n_checks++; if (hit_flash !== 1'b0) $display("FAIL reset_flash got %0b exp 0", hit_flash); else n_pass++;
    n_checks++; if (f_speed !== 32'd60000) $display("FAIL reset_fast_speed got %0d exp 60000", f_speed); else n_pass++;
  endtask

  task automatic test_start_play();
    press_start();
    for (int f = 0; f < 3; f++) drive_frame(6, -1, 0);
    idle(3);
    @(negedge clock_25mhz);
    n_checks++; if (state_dbg !== 2'(P_PLAYING)) $display("FAIL play_state got %0d exp %0d", state_dbg, P_PLAYING); else n_pass++;
    n_checks++; if (score !== 16'd3) $display("FAIL play_score got %0d exp 3", score); else n_pass++;
    n_checks++; if (lives !== 2'd3) $display("FAIL play_lives got %0d exp 3", lives); else n_pass++;
    n_checks++; if (speed !== 32'd250000) $display("FAIL play_speed got %0d exp 250000", speed); else n_pass++;
    n_checks++; if (game_active !== 1'b1) $display("FAIL play_active got %0b exp 1", game_active); else n_pass++;
    n_checks++; if (f_speed !== 32'd50000) $display("FAIL fast_speed_3f got %0d exp 50000", f_speed); else n_pass++;
    n_checks++; if (f_score !== 16'hFFFF) $display("FAIL fast_score_sat got %0h exp ffff", f_score); else n_pass++;
  endtask

  task automatic test_hit_grace();
    drive_frame(8, -1, 500);
    drive_frame(8, 2, 500);
    for (int f = 0; f < 60; f++) begin
      drive_frame(5, $urandom_range(1, 4), 0);
      @(negedge clock_25mhz);
      n_checks++; if (hit_flash !== 1'b1) $display("FAIL grace_flash f%0d got %0b exp 1", f, hit_flash); else n_pass++;
      n_checks++; if (lives !== 2'd2) $display("FAIL grace_lives f%0d got %0d exp 2", f, lives); else n_pass++;
    end
    drive_frame(5, -1, 0);
    @(negedge clock_25mhz);
    n_checks++; if (state_dbg !== 2'(P_PLAYING)) $display("FAIL grace_exit_state got %0d exp %0d", state_dbg, P_PLAYING); else n_pass++;
    n_checks++; if (hit_flash !== 1'b0) $display("FAIL grace_exit_flash got %0b exp 0", hit_flash); else n_pass++;
    n_checks++; if (score !== 16'd65) $display("FAIL grace_exit_score got %0d exp 65", score); else n_pass++;
    n_checks++; if (lives !== 2'(m_lives)) $display("FAIL grace_exit_lives got %0d exp %0d", lives, m_lives); else n_pass++;
  endtask

  task automatic test_reset_mid_game();
    do_reset();
    press_start();
    drive_frame(6, 3, 0);
    drive_frame(6, -1, 0);
    @(negedge clock_25mhz);
    n_checks++; if (state_dbg !== 2'(P_GRACE)) $display("FAIL mid_pre_state got %0d exp %0d", state_dbg, P_GRACE); else n_pass++;
    n_checks++; if (lives !== 2'd2) $display("FAIL mid_pre_lives got %0d exp 2", lives); else n_pass++;
    reset = 1'b1;
    pixel_index = '0;
    cyc();
    model_reset();
    @(negedge clock_25mhz);
    n_checks++; if (state_dbg !== 2'(P_IDLE)) $display("FAIL mid_reset_state got %0d exp %0d", state_dbg, P_IDLE); else n_pass++;
    n_checks++; if (lives !== 2'd0) $display("FAIL mid_reset_lives got %0d exp 0", lives); else n_pass++;
    n_checks++; if (game_active !== 1'b0) $display("FAIL mid_reset_active got %0b exp 0", game_active); else n_pass++;
    n_checks++; if (speed !== 32'd250000) $display("FAIL mid_reset_speed got %0d exp 250000", speed); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_game_over();
    logic [15:0] held_score;
    press_start();
    for (int h = 0; h < 3; h++) begin
      drive_frame(6, 4, 0);
      drive_frame(6, -1, 0);
      if (h == 0) begin
        press_start();
        @(negedge clock_25mhz);
        n_checks++; if (state_dbg !== 2'(P_GRACE)) $display("FAIL start_in_grace got %0d exp %0d", state_dbg, P_GRACE); else n_pass++;
        n_checks++; if (lives !== 2'd2) $display("FAIL start_in_grace_lives got %0d exp 2", lives); else n_pass++;
      end
      for (int i = 0; i < 70 && m_state == P_GRACE; i++) drive_frame(4, -1, 0);
    end
    @(negedge clock_25mhz);
    n_checks++; if (lives !== 2'd0) $display("FAIL over_lives got %0d exp 0", lives); else n_pass++;
    n_checks++; if (game_over !== 1'b1) $display("FAIL over_flag got %0b exp 1", game_over); else n_pass++;
    n_checks++; if (game_active !== 1'b0) $display("FAIL over_active got %0b exp 0", game_active); else n_pass++;
    held_score = score;
    for (int f = 0; f < 3; f++) drive_frame(5, 2, 0);
    idle(3);
    @(negedge clock_25mhz);
    n_checks++; if (score !== 16'(exp_score(0))) $display("FAIL over_score_hold got %0d exp %0d", score, exp_score(0)); else n_pass++;
    n_checks++; if (score !== held_score) $display("FAIL over_score_moved got %0d exp %0d", score, held_score); else n_pass++;
    press_start();
    @(negedge clock_25mhz);
    n_checks++; if (lives !== 2'd3) $display("FAIL restart_lives got %0d exp 3", lives); else n_pass++;
    n_checks++; if (score !== 16'd0) $display("FAIL restart_score got %0d exp 0", score); else n_pass++;
    n_checks++; if (state_dbg !== 2'(P_PLAYING)) $display("FAIL restart_state got %0d exp %0d", state_dbg, P_PLAYING); else n_pass++;
  endtask

  task automatic test_frame_end_overlap();
    drive_frame(6, -1, 0);
    drive_frame(6, 1, 0);
    @(negedge clock_25mhz);
    n_checks++; if (state_dbg !== 2'(P_PLAYING)) $display("FAIL fe_overlap_cur_state got %0d exp %0d", state_dbg, P_PLAYING); else n_pass++;
    n_checks++; if (lives !== 2'd3) $display("FAIL fe_overlap_cur_lives got %0d exp 3", lives); else n_pass++;
    drive_frame(6, -1, 0);
    @(negedge clock_25mhz);
    n_checks++; if (state_dbg !== 2'(P_GRACE)) $display("FAIL fe_overlap_next_state got %0d exp %0d", state_dbg, P_GRACE); else n_pass++;
    n_checks++; if (lives !== 2'd2) $display("FAIL fe_overlap_next_lives got %0d exp 2", lives); else n_pass++;
  endtask

  task automatic test_random();
    int n;
    int hit_idx;
    logic [15:0] exp_score_v;
    do_reset();
    press_start();
    for (int f = 0; f < 200; f++) begin
      if (m_state == P_OVER || $urandom_range(0, 39) == 0) press_start();
      n = $urandom_range(3, 10);
      hit_idx = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n - 1) : -1;
      drive_frame(n, hit_idx, 0);
      exp_q.push_back(16'(exp_score(0)));
      @(negedge clock_25mhz);
      exp_score_v = exp_q.pop_front();
      n_checks++; if (score !== exp_score_v) $display("FAIL rand_score f%0d got %0d exp %0d", f, score, exp_score_v); else n_pass++;
      n_checks++; if (state_dbg !== 2'(m_state)) $display("FAIL rand_state f%0d got %0d exp %0d", f, state_dbg, m_state); else n_pass++;
      n_checks++; if (lives !== 2'(m_lives)) $display("FAIL rand_lives f%0d got %0d exp %0d", f, lives, m_lives); else n_pass++;
      n_checks++; if (hit_flash !== (m_state == P_GRACE)) $display("FAIL rand_flash f%0d got %0b exp %0b", f, hit_flash, m_state == P_GRACE); else n_pass++;
      n_checks++; if (speed !== 32'(exp_speed(250000, 600))) $display("FAIL rand_speed f%0d got %0d exp %0d", f, speed, exp_speed(250000, 600)); else n_pass++;
      n_checks++; if (f_speed !== 32'(exp_speed(60000, 2))) $display("FAIL rand_fast_speed f%0d got %0d exp %0d", f, f_speed, exp_speed(60000, 2)); else n_pass++;
      n_checks++; if (f_score !== 16'(exp_score(65534))) $display("FAIL rand_fast_score f%0d got %0h exp %0h", f, f_score, exp_score(65534)); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_start_play();
    test_hit_grace();
    test_reset_mid_game();
    test_game_over();
    test_frame_end_overlap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
